// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline.
// Drives bubble/flush pairs for PC, IF/ID, ID/EX, EX/MEM and MEM/WB,
// tracks data-memory misses with a bounded wait, and keeps saturating
// stall/redirect counters plus a sticky miss-timeout flag.
//
//   state         | meaning
//   --------------+--------------------------------------------------
//   ST_RUN        | normal flow; a new miss stalls from its first cycle
//   ST_MISS_WAIT  | waiting for miss_ack; whole front end frozen, WB flushed
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [4:0]       reg_dstE,
  input  logic             load_E,
  input  logic             br_E,
  input  logic             jalr_E,
  input  logic             jal_D,
  input  logic             miss_req,
  input  logic             miss_ack,
  output logic             bubbleF,
  output logic             flushF,
  output logic             bubbleD,
  output logic             flushD,
  output logic             bubbleE,
  output logic             flushE,
  output logic             bubbleM,
  output logic             flushM,
  output logic             bubbleW,
  output logic             flushW,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ST_RUN,
    ST_MISS_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;

  logic miss_active;
  logic load_use;
  logic redirect;
  logic jal_flush;

  // Hazard conditions, already qualified by the priority order.
  always_comb begin
    load_use    = load_E && (reg_dstE != 5'd0) &&
                  ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));
    miss_active = (state_q == ST_MISS_WAIT) ||
                  ((state_q == ST_RUN) && miss_req && !miss_ack);
    redirect    = rst_n && !miss_active && (br_E || jalr_E);
    jal_flush   = rst_n && !miss_active && !(br_E || jalr_E) && !load_use && jal_D;
  end

  // Mealy bubble/flush outputs so control acts on the same posedge.
  always_comb begin
    bubbleF = 1'b0; flushF = 1'b0;
    bubbleD = 1'b0; flushD = 1'b0;
    bubbleE = 1'b0; flushE = 1'b0;
    bubbleM = 1'b0; flushM = 1'b0;
    bubbleW = 1'b0; flushW = 1'b0;
    if (!rst_n) begin
      flushF = 1'b1; flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
    end else if (miss_active) begin
      // Freeze everything up to MEM; WB gets a bubble instead of a stale result.
      bubbleF = 1'b1; bubbleD = 1'b1; bubbleE = 1'b1; bubbleM = 1'b1;
      flushW  = 1'b1;
    end else if (br_E || jalr_E) begin
      // Redirect squashes the wrong-path instructions; any load-use is moot.
      flushD = 1'b1; flushE = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1; bubbleD = 1'b1; flushE = 1'b1;
    end else if (jal_D) begin
      flushD = 1'b1;
    end
  end

  // Miss-wait FSM, sticky timeout and saturating counters.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    case (state_q)
      ST_RUN: begin
        if (miss_req && !miss_ack) begin
          state_d = ST_MISS_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MISS_WAIT: begin
        if (miss_ack) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
          // Forced release so a hung memory cannot deadlock the core.
          timeout_d = 1'b1;
          state_d   = ST_RUN;
          wcnt_d    = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
    if (bubbleF && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if ((redirect || jal_flush) && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign miss_timeout = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a reference model predicts
// each cycle's controls and post-edge counters into a scoreboard queue.
module tb_pipe_hazard_ctrl;

  localparam int MW  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [4:0]    reg1_srcD, reg2_srcD, reg_dstE;
  logic          load_E, br_E, jalr_E, jal_D, miss_req, miss_ack;
  logic          bubbleF, flushF, bubbleD, flushD, bubbleE, flushE;
  logic          bubbleM, flushM, bubbleW, flushW;
  logic          miss_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD), .reg_dstE(reg_dstE),
    .load_E(load_E), .br_E(br_E), .jalr_E(jalr_E), .jal_D(jal_D),
    .miss_req(miss_req), .miss_ack(miss_ack),
    .bubbleF(bubbleF), .flushF(flushF), .bubbleD(bubbleD), .flushD(flushD),
    .bubbleE(bubbleE), .flushE(flushE), .bubbleM(bubbleM), .flushM(flushM),
    .bubbleW(bubbleW), .flushW(flushW),
    .miss_timeout(miss_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  wire [9:0] ctl = {bubbleF, flushF, bubbleD, flushD, bubbleE, flushE,
                    bubbleM, flushM, bubbleW, flushW};

  typedef struct {
    logic [9:0] ctl;
    int         stall;
    int         flsh;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit m_miss  = 1'b0;
  int m_w     = 0;
  bit m_to    = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    load_E = 1'b0; br_E = 1'b0; jalr_E = 1'b0; jal_D = 1'b0;
    miss_req = 1'b0; miss_ack = 1'b0;
    reg1_srcD = 5'd0; reg2_srcD = 5'd0; reg_dstE = 5'd0;
    rst_n = 1'b1;
  endtask

  // One clock: predict, push, sample controls before the edge, counters after.
  task automatic step(input string tag);
    exp_t       e;
    logic [9:0] c;
    logic [9:0] got_ctl;
    bit         lu, ma, rd, jf;
    #1;
    lu = load_E && (reg_dstE != 5'd0) &&
         ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));
    ma = m_miss || (miss_req && !miss_ack);
    rd = 1'b0;
    jf = 1'b0;
    if (!rst_n)              c = 10'b01_01_01_01_01;
    else if (ma)             c = 10'b10_10_10_10_01;
    else if (br_E || jalr_E) begin c = 10'b00_01_01_00_00; rd = 1'b1; end
    else if (lu)             c = 10'b10_10_01_00_00;
    else if (jal_D)          begin c = 10'b00_01_00_00_00; jf = 1'b1; end
    else                     c = 10'b0;
    if (!rst_n) begin
      m_miss = 1'b0; m_w = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (c[9] && m_stall < SAT) m_stall++;
      if ((rd || jf) && m_flush < SAT) m_flush++;
      if (!m_miss) begin
        if (miss_req && !miss_ack) begin m_miss = 1'b1; m_w = 1; end
      end else if (miss_ack) begin
        m_miss = 1'b0; m_w = 0;
      end else if (m_w == MW) begin
        m_to = 1'b1; m_miss = 1'b0; m_w = 0;
      end else begin
        m_w++;
      end
    end
    e.ctl = c; e.stall = m_stall; e.flsh = m_flush; e.to = m_to;
    sb.push_back(e);
    got_ctl = ctl;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ctl"},   {22'd0, got_ctl}, {22'd0, e.ctl});
      chk({tag, ".stall"}, {28'd0, stall_cycles}, e.stall);
      chk({tag, ".flush"}, {28'd0, flush_events}, e.flsh);
      chk({tag, ".tmo"},   {31'd0, miss_timeout}, {31'd0, e.to});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step("rst");
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
    chk("rst_tmo", {31'd0, miss_timeout}, 32'd0);

    // load-use on rs1, then rd=x0 must not stall, then rs2 match
    load_E = 1'b1; reg_dstE = 5'd5; reg1_srcD = 5'd5;
    step("lu_rs1");
    idle(); step("lu_after");
    chk("lu_stall_cnt", {28'd0, stall_cycles}, 32'd1);
    load_E = 1'b1; reg_dstE = 5'd0; reg1_srcD = 5'd0;
    step("lu_x0");
    load_E = 1'b1; reg_dstE = 5'd7; reg1_srcD = 5'd3; reg2_srcD = 5'd7;
    step("lu_rs2");
    load_E = 1'b0;
    step("no_load");
    load_E = 1'b1; reg2_srcD = 5'd8;
    step("lu_nomatch");

    // branch/jump priority over load-use, JAL loses to load-use
    idle();
    load_E = 1'b1; reg_dstE = 5'd5; reg1_srcD = 5'd5; br_E = 1'b1;
    step("br_lu");
    chk("br_flush_cnt", {28'd0, flush_events}, 32'd1);
    br_E = 1'b0; jalr_E = 1'b1;
    step("jalr_lu");
    jalr_E = 1'b0; load_E = 1'b0; jal_D = 1'b1;
    step("jal");
    load_E = 1'b1;
    step("jal_lu");
    idle(); step("idle");
    chk("redir_flush_cnt", {28'd0, flush_events}, 32'd3);

    // miss: 4 waiting cycles, ack on the 5th
    do_reset();
    miss_req = 1'b1;
    repeat (4) step("miss");
    miss_ack = 1'b1; br_E = 1'b1;
    step("miss_ack");
    idle(); step("miss_done");
    chk("miss_stall_cnt", {28'd0, stall_cycles}, 32'd5);
    miss_req = 1'b1; miss_ack = 1'b1;
    step("hit_same_cycle");
    idle(); step("hit_after");
    chk("hit_stall_cnt", {28'd0, stall_cycles}, 32'd5);

    // timeout with no ack
    do_reset();
    miss_req = 1'b1; jal_D = 1'b1;
    repeat (4) step("to_wait");
    chk("to_early", {31'd0, miss_timeout}, 32'd0);
    jal_D = 1'b0;
    step("to_5th");
    chk("to_set", {31'd0, miss_timeout}, 32'd1);
    idle();
    repeat (3) step("to_hold");
    chk("to_sticky", {31'd0, miss_timeout}, 32'd1);
    chk("to_stall_cnt", {28'd0, stall_cycles}, 32'd5);

    // reset in the middle of a miss
    miss_req = 1'b1;
    step("mid_miss");
    step("mid_miss");
    rst_n = 1'b0;
    step("rst_mid");
    chk("rst_mid_stall", {28'd0, stall_cycles}, 32'd0);
    chk("rst_mid_tmo", {31'd0, miss_timeout}, 32'd0);
    idle();
    step("post_rst");

    // counter saturation
    do_reset();
    load_E = 1'b1; reg_dstE = 5'd5; reg1_srcD = 5'd5;
    repeat (20) step("sat_lu");
    chk("sat_stall", {28'd0, stall_cycles}, 32'd15);
    idle(); jal_D = 1'b1;
    repeat (20) step("sat_jal");
    chk("sat_flush", {28'd0, flush_events}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the five-stage RV32I pipeline. It drives the bubble/flush pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers and the PC register. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory misses. It also keeps saturating performance counters and a sticky miss-timeout flag.

Parameters:
MAX_WAIT, 64, maximum miss-wait cycles before timeout (≥2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
reg1_srcD  in  5  rs1 of instruction in ID
reg2_srcD  in  5  rs2 of instruction in ID
reg_dstE  in  5  rd of instruction in EX
load_E  in  1  instruction in EX is a load
br_E  in  1  branch in EX resolved taken
jalr_E  in  1  JALR in EX
jal_D  in  1  JAL decoded in ID
miss_req  in  1  data memory in MEM cannot complete this cycle (level)
miss_ack  in  1  data memory completes the pending access this cycle
bubbleF, flushF  out  1 each  PC register control
bubbleD, flushD  out  1 each  IF/ID control
bubbleE, flushE  out  1 each  ID/EX control
bubbleM, flushM  out  1 each  EX/MEM control
bubbleW, flushW  out  1 each  MEM/WB control
miss_timeout  out  1  sticky, set when a miss exceeds MAX_WAIT
stall_cycles  out  CNT_W  cycles with bubbleF=1, saturating
flush_events  out  CNT_W  branch/jump redirects, saturating

Behaviour:
- Bubble and flush outputs are combinational (Mealy) from the state and the current inputs, so control takes effect at the same posedge. Segment registers hold on bubble; flush clears only when bubble=0.
- FSM states: RUN and MISS_WAIT. Each has a wait counter wcnt of width clog2(MAX_WAIT+1).
- Reset (rst_n=0, sampled at posedge):
  - state←RUN, wcnt←0, counters←0, miss_timeout←0.
  - While rst_n=0, all flush*=1 and all bubble*=0, so the segment registers clear.
- miss_active = (state==MISS_WAIT) | (state==RUN & miss_req & !miss_ack).
- Priority, highest first:
  1. Reset.
  2. miss_active: bubbleF/D/E/M=1, flushW=1, all others 0. Branch, jump and load-use inputs are ignored.
  3. br_E | jalr_E: flushD=1, flushE=1. Any load-use condition is discarded.
  4. Load-use, defined as load_E & reg_dstE≠0 & (reg_dstE==reg1_srcD | reg_dstE==reg2_srcD): bubbleF=1, bubbleD=1, flushE=1.
  5. jal_D: flushD=1.
  6. Otherwise all outputs 0.
- Cases 4 and 5 together: load-use wins. JAL is re-evaluated next cycle.
- FSM transitions:
  - RUN → MISS_WAIT when miss_req & !miss_ack; wcnt←1.
  - If miss_req & miss_ack in RUN: state stays RUN, no stall.
  - In MISS_WAIT, miss_ack=1: → RUN next cycle, wcnt←0. The ack cycle itself is still stalled, and the pipeline advances on the following posedge.
  - In MISS_WAIT, !miss_ack and wcnt==MAX_WAIT: miss_timeout←1, → RUN, wcnt←0. This forced release prevents a hung memory from deadlocking the core.
  - Otherwise wcnt←wcnt+1.
- miss_timeout clears only on reset.
- Counters:
  - stall_cycles increments on each posedge with bubbleF=1 and rst_n=1.
  - flush_events increments on each posedge where case 3 or case 5 is active.
  - Both saturate at 2^CNT_W−1 and never wrap.

Test Plan:
- Load-use: load_E=1, reg_dstE=5, reg1_srcD=5 for one cycle → bubbleF=bubbleD=flushE=1 that cycle, stall_cycles=1. Same stimulus with reg_dstE=0 → all outputs 0.
- Branch vs. load-use: br_E=1 with a load-use condition also present → flushD=flushE=1, bubbleF=0, flush_events +1.
- Miss: miss_req=1 for 4 cycles, then miss_ack=1 on the 5th → bubbleF/D/E/M=1 and flushW=1 for 5 cycles, state back to RUN on the 6th, stall_cycles=5.
- Timeout: MAX_WAIT=4, miss_req held and no ack → miss_timeout=1 after the 5th stall cycle, state RUN, flag remains 1 until rst_n=0.
- Reset mid-miss: rst_n=0 during MISS_WAIT → next cycle state RUN and counters 0. During reset all flush*=1 and bubble*=0.
- Saturation: CNT_W=4, 20 load-use cycles → stall_cycles=15.
